// File: rtl/rl11dma.sv
// rtl/rl11dma.sv - Unibus NPR bus-master sequencer for the RL11 disk path
module rl11dma #(
  parameter int DESKEW = 3,
  parameter int NXMCYC = 1000
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        armwrite,
  input  logic [2:0]  armraddr,
  input  logic [2:0]  armwaddr,
  input  logic [31:0] armwdata,
  output logic [31:0] armrdata,
  output logic        armintrq,
  input  logic        init_in_h,
  output logic        npr_out_h,
  input  logic        npg_in_h,
  output logic        sack_out_h,
  input  logic        bbsy_in_h,
  output logic        bbsy_out_h,
  output logic [17:0] a_out_h,
  output logic [1:0]  c_out_h,
  output logic [15:0] d_out_h,
  output logic        msyn_out_h,
  input  logic        ssyn_in_h,
  input  logic [15:0] d_in_h
);

  localparam int TW = $clog2(NXMCYC + 1);
  localparam int DW = $clog2(DESKEW + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_GNT    = 3'd2,
    S_ADDR   = 3'd3,
    S_WAITS  = 3'd4,
    S_WAITNS = 3'd5,
    S_REL    = 3'd6
  } state_t;

  state_t        state;
  logic [17:0]   addr;
  logic [4:0]    count;
  logic          dir;
  logic [4:0]    ptr;
  logic [4:0]    idx;
  logic          busy;
  logic          done;
  logic          nxm;
  logic          abort;
  logic [DW-1:0] dcnt;
  logic [TW-1:0] tcnt;
  logic [15:0]   buffer [32];

  logic          start_req;
  logic          buf_wr_arm;
  logic          ptr_wr_arm;
  logic          dati_capture;
  logic [17:0]   addr_next;
  logic [4:0]    idx_next;
  logic [1:0]    cyc_type;
  logic [2:0]    state_code;
  logic          unused_bits;

  // ARM-side strobes; buffer and pointer are frozen while a transfer owns them
  assign start_req    = armwrite && (armwaddr == 3'd1) && armwdata[31] && !busy;
  assign buf_wr_arm   = armwrite && (armwaddr == 3'd2) && !busy;
  assign ptr_wr_arm   = armwrite && (armwaddr == 3'd3) && !busy;
  assign dati_capture = (state == S_WAITS) && ssyn_in_h && !dir && !init_in_h;
  assign addr_next    = addr + 18'd2;
  assign idx_next     = idx + 5'd1;
  assign cyc_type     = dir ? 2'b10 : 2'b00;
  assign state_code   = state;
  assign armintrq     = done;
  assign unused_bits  = ^armwdata[30:24];

  // Word buffer: ARM loads it when idle, DATI cycles fill it during a burst
  always_ff @(posedge CLOCK) begin
    if (dati_capture) begin
      buffer[idx] <= d_in_h;
    end else if (buf_wr_arm) begin
      buffer[ptr] <= armwdata[15:0];
    end
  end

  // ARM buffer pointer: auto-increments on data writes, loadable or steppable via reg 3
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      ptr <= 5'd0;
    end else if (buf_wr_arm) begin
      ptr <= ptr + 5'd1;
    end else if (ptr_wr_arm) begin
      ptr <= armwdata[31] ? ptr + 5'd1 : armwdata[4:0];
    end
  end

  // Bus sequencer: arbitration, per-word DATI/DATO handshake, NXM timeout and INIT abort
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state      <= S_IDLE;
      addr       <= 18'd0;
      count      <= 5'd0;
      dir        <= 1'b0;
      idx        <= 5'd0;
      busy       <= 1'b0;
      done       <= 1'b1;
      nxm        <= 1'b0;
      abort      <= 1'b0;
      dcnt       <= '0;
      tcnt       <= '0;
      npr_out_h  <= 1'b0;
      sack_out_h <= 1'b0;
      bbsy_out_h <= 1'b0;
      a_out_h    <= 18'd0;
      c_out_h    <= 2'b00;
      d_out_h    <= 16'd0;
      msyn_out_h <= 1'b0;
    end else if (init_in_h && (state != S_IDLE)) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b1;
      abort      <= 1'b1;
      npr_out_h  <= 1'b0;
      sack_out_h <= 1'b0;
      bbsy_out_h <= 1'b0;
      a_out_h    <= 18'd0;
      c_out_h    <= 2'b00;
      d_out_h    <= 16'd0;
      msyn_out_h <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_req) begin
            addr      <= {armwdata[17:1], 1'b0};
            count     <= armwdata[22:18];
            dir       <= armwdata[23];
            idx       <= 5'd0;
            busy      <= 1'b1;
            done      <= 1'b0;
            nxm       <= 1'b0;
            abort     <= 1'b0;
            npr_out_h <= 1'b1;
            state     <= S_REQ;
          end
        end
        S_REQ: begin
          if (npg_in_h && !bbsy_in_h && !ssyn_in_h) begin
            sack_out_h <= 1'b1;
            npr_out_h  <= 1'b0;
            state      <= S_GNT;
          end
        end
        S_GNT: begin
          if (!npg_in_h && !bbsy_in_h) begin
            bbsy_out_h <= 1'b1;
            sack_out_h <= 1'b0;
            a_out_h    <= addr;
            c_out_h    <= cyc_type;
            d_out_h    <= dir ? buffer[idx] : 16'd0;
            dcnt       <= '0;
            state      <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (dcnt == DW'(DESKEW - 1)) begin
            msyn_out_h <= 1'b1;
            tcnt       <= '0;
            state      <= S_WAITS;
          end else begin
            dcnt <= dcnt + DW'(1);
          end
        end
        S_WAITS: begin
          if (ssyn_in_h) begin
            msyn_out_h <= 1'b0;
            state      <= S_WAITNS;
          end else if (tcnt == TW'(NXMCYC - 1)) begin
            nxm        <= 1'b1;
            msyn_out_h <= 1'b0;
            state      <= S_REL;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        S_WAITNS: begin
          if (!ssyn_in_h) begin
            addr <= addr_next;
            idx  <= idx_next;
            if (count == 5'd0) begin
              state <= S_REL;
            end else begin
              count   <= count - 5'd1;
              a_out_h <= addr_next;
              d_out_h <= dir ? buffer[idx_next] : 16'd0;
              dcnt    <= '0;
              state   <= S_ADDR;
            end
          end
        end
        S_REL: begin
          bbsy_out_h <= 1'b0;
          a_out_h    <= 18'd0;
          c_out_h    <= 2'b00;
          d_out_h    <= 16'd0;
          msyn_out_h <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b1;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // ARM read mux over registered state
  always_comb begin
    armrdata = 32'd0;
    case (armraddr)
      3'd0: armrdata = 32'h444D1001;
      3'd1: armrdata = {done, busy, 1'b0, nxm, abort, state_code, dir, count, addr};
      3'd2: armrdata = {11'b0, ptr, buffer[ptr]};
      default: armrdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_rl11dma.sv
// tb/tb_rl11dma.sv - randomized self-checking bench for rl11dma
module tb_rl11dma;

  localparam int DESKEW = 3;
  localparam int NXMCYC = 1000;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b1;
  logic        armwrite = 1'b0;
  logic [2:0]  armraddr = 3'd0;
  logic [2:0]  armwaddr = 3'd0;
  logic [31:0] armwdata = 32'd0;
  logic [31:0] armrdata;
  logic        armintrq;
  logic        init_in_h = 1'b0;
  logic        npr_out_h;
  logic        npg_in_h = 1'b0;
  logic        sack_out_h;
  logic        bbsy_in_h = 1'b0;
  logic        bbsy_out_h;
  logic [17:0] a_out_h;
  logic [1:0]  c_out_h;
  logic [15:0] d_out_h;
  logic        msyn_out_h;
  logic        ssyn_in_h = 1'b0;
  logic [15:0] d_in_h = 16'd0;

  rl11dma #(.DESKEW(DESKEW), .NXMCYC(NXMCYC)) dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .armwrite(armwrite), .armraddr(armraddr), .armwaddr(armwaddr),
    .armwdata(armwdata), .armrdata(armrdata), .armintrq(armintrq),
    .init_in_h(init_in_h), .npr_out_h(npr_out_h), .npg_in_h(npg_in_h),
    .sack_out_h(sack_out_h), .bbsy_in_h(bbsy_in_h), .bbsy_out_h(bbsy_out_h),
    .a_out_h(a_out_h), .c_out_h(c_out_h), .d_out_h(d_out_h),
    .msyn_out_h(msyn_out_h), .ssyn_in_h(ssyn_in_h), .d_in_h(d_in_h)
  );

  always #5 CLOCK = ~CLOCK;

  int compared = 0;
  int mismatched = 0;

  // reference state
  logic [15:0] bufm [32];
  logic [15:0] mem [int];
  int          ptr_m = 0;

  // slave log of every bus cycle that reached SSYN
  logic [17:0] log_a [$];
  logic [1:0]  log_c [$];
  logic [15:0] log_d [$];
  bit          slave_en = 1'b1;
  int          slave_delay = 2;
  int          sg;

  // bus monitor
  logic [20:0] prev_key = '0;
  logic [20:0] key;
  logic        prev_msyn = 1'b0;
  logic        prev_bbsy = 1'b0;
  int          age = 0;
  int          deskew_err = 0;
  int          msyn_len = 0;
  int          last_msyn_len = 0;
  int          bbsy_rises = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] word_addr(input logic [17:0] a, input int k);
    return {a[17:1], 1'b0} + 18'(2 * k);
  endfunction

  function automatic logic [38:0] bus_outs();
    return {npr_out_h, sack_out_h, bbsy_out_h, a_out_h, c_out_h, d_out_h, msyn_out_h};
  endfunction

  task automatic arm_write(input logic [2:0] r, input logic [31:0] v);
    @(negedge CLOCK);
    armwaddr = r;
    armwdata = v;
    armwrite = 1'b1;
    @(negedge CLOCK);
    armwrite = 1'b0;
  endtask

  task automatic arm_read(input logic [2:0] r, output logic [31:0] v);
    @(negedge CLOCK);
    armraddr = r;
    #1 v = armrdata;
  endtask

  task automatic load_buf(input int n);
    arm_write(3'd3, 32'd0);
    for (int k = 0; k < n; k++) arm_write(3'd2, {16'd0, bufm[k]});
    ptr_m = n % 32;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!armintrq && n < 40000) begin
      @(negedge CLOCK);
      n++;
    end
    check("done_wait", armintrq, 1'b1);
  endtask

  task automatic grant(input bit guard, input logic [17:0] a);
    int n;
    logic [31:0] r;
    n = 0;
    while (!npr_out_h && n < 50) begin
      @(negedge CLOCK);
      n++;
    end
    check("npr_asserted", npr_out_h, 1'b1);
    if (guard) begin
      bbsy_in_h = 1'b1;
      npg_in_h  = 1'b1;
      repeat (8) @(negedge CLOCK);
      check("guard_no_sack", sack_out_h, 1'b0);
      arm_read(3'd1, r);
      check("guard_state_req", {r[30], r[26:24]}, {1'b1, 3'd1});
      arm_write(3'd1, {1'b1, 7'd0, 1'b0, 5'd7, a + 18'o100});
      arm_write(3'd2, 32'h0000DEAD);
      arm_write(3'd3, 32'd5);
      arm_read(3'd1, r);
      check("guard_addr_kept", r[23:0], {1'b1, 5'd3, word_addr(a, 0)});
      check("guard_still_no_sack", sack_out_h, 1'b0);
      bbsy_in_h = 1'b0;
    end
    npg_in_h = 1'b1;
    n = 0;
    while (!sack_out_h && n < 50) begin
      @(negedge CLOCK);
      n++;
    end
    check("sack_asserted", sack_out_h, 1'b1);
    check("npr_dropped", npr_out_h, 1'b0);
    npg_in_h = 1'b0;
  endtask

  task automatic do_xfer(input logic [17:0] a, input int cnt, input bit dir,
                         input int dly, input bit guard);
    logic [31:0] r;
    int rises0;
    slave_delay = dly;
    log_a.delete();
    log_c.delete();
    log_d.delete();
    rises0 = bbsy_rises;
    deskew_err = 0;
    arm_write(3'd1, {1'b1, 7'd0, dir, 5'(cnt), a});
    grant(guard, a);
    wait_done();
    check("word_count", log_a.size(), cnt + 1);
    for (int k = 0; k <= cnt; k++) begin
      if (k < log_a.size()) begin
        check("bus_addr", log_a[k], word_addr(a, k));
        check("bus_ctrl", log_c[k], dir ? 2'b10 : 2'b00);
        check("bus_data", log_d[k], dir ? bufm[k] : 16'd0);
      end
      if (dir) mem[int'(word_addr(a, k))] = bufm[k];
      else bufm[k] = mem[int'(word_addr(a, k))];
    end
    check("one_tenure", bbsy_rises - rises0, 1);
    check("deskew", deskew_err, 0);
    check("bus_released", bus_outs(), 39'd0);
    arm_read(3'd1, r);
    check("reg1_end", r, {1'b1, 4'b0, 3'd0, dir, 5'd0, word_addr(a, cnt + 1)});
    if (!dir) begin
      for (int k = 0; k <= cnt; k++) begin
        arm_write(3'd3, 32'(k));
        arm_read(3'd2, r);
        check("dati_buf", r, {11'd0, 5'(k), bufm[k]});
      end
      ptr_m = cnt;
    end
  endtask

  // slave: answers MSYN with SSYN after slave_delay cycles and logs the cycle
  always begin
    @(negedge CLOCK);
    if (msyn_out_h && slave_en && !ssyn_in_h) begin
      for (int k = 0; k < slave_delay && msyn_out_h; k++) @(negedge CLOCK);
      if (msyn_out_h) begin
        log_a.push_back(a_out_h);
        log_c.push_back(c_out_h);
        log_d.push_back(d_out_h);
        if (c_out_h == 2'b00)
          d_in_h = mem.exists(int'(a_out_h)) ? mem[int'(a_out_h)] : 16'd0;
        ssyn_in_h = 1'b1;
        sg = 0;
        while (msyn_out_h && sg < 3000) begin
          @(negedge CLOCK);
          sg++;
        end
        ssyn_in_h = 1'b0;
        d_in_h = 16'd0;
      end
    end
  end

  // monitor: address-to-MSYN deskew, MSYN width, bus tenures
  always @(negedge CLOCK) begin
    key = {bbsy_out_h, c_out_h, a_out_h};
    if (msyn_out_h && !prev_msyn) begin
      if (age != DESKEW) deskew_err++;
    end
    if (key != prev_key) age = 1;
    else if (!msyn_out_h) age++;
    if (msyn_out_h) msyn_len++;
    else if (prev_msyn) begin
      last_msyn_len = msyn_len;
      msyn_len = 0;
    end
    if (bbsy_out_h && !prev_bbsy) bbsy_rises++;
    prev_key  = key;
    prev_msyn = msyn_out_h;
    prev_bbsy = bbsy_out_h;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] r;
  logic [17:0] ra;
  int          rc;
  bit          rd;
  int          n;

  initial begin
    // reset
    repeat (3) @(negedge CLOCK);
    RESET = 1'b0;
    arm_read(3'd0, r);
    check("reg0_id", r, 32'h444D1001);
    arm_read(3'd1, r);
    check("reg1_reset", r, 32'h80000000);
    check("intrq_reset", armintrq, 1'b1);
    check("bus_reset", bus_outs(), 39'd0);

    // buffer pointer handling
    for (int k = 0; k < 32; k++) bufm[k] = 16'($urandom);
    load_buf(32);
    arm_read(3'd2, r);
    check("ptr_wrap", r, {11'd0, 5'd0, bufm[0]});
    arm_write(3'd3, 32'h80000000);
    arm_read(3'd2, r);
    check("ptr_step", r, {11'd0, 5'd1, bufm[1]});
    arm_write(3'd3, 32'd7);
    arm_read(3'd2, r);
    check("ptr_load", r, {11'd0, 5'd7, bufm[7]});

    // single DATO, slave answers 5 cycles after MSYN
    bufm[0] = 16'o123456;
    load_buf(1);
    do_xfer(18'o1000, 0, 1'b1, 5, 1'b0);
    check("dato_d", log_d.size() > 0 ? log_d[0] : 16'hxxxx, 16'o123456);

    // 4-word DATI burst
    for (int k = 0; k < 4; k++) mem[int'(word_addr(18'o2000, k))] = 16'(k + 1);
    do_xfer(18'o2000, 3, 1'b0, 1, 1'b0);
    check("dati_last", bufm[3], 16'd4);

    // address wrap
    bufm[0] = 16'($urandom);
    bufm[1] = 16'($urandom);
    load_buf(2);
    do_xfer(18'o777776, 1, 1'b1, 0, 1'b0);
    check("wrap_second", log_a.size() > 1 ? log_a[1] : 18'h3ffff, 18'd0);

    // NXM: nobody answers
    slave_en = 1'b0;
    arm_write(3'd1, {1'b1, 7'd0, 1'b0, 5'd2, 18'o7000});
    grant(1'b0, 18'o7000);
    wait_done();
    check("nxm_msyn_width", last_msyn_len, NXMCYC);
    arm_read(3'd1, r);
    check("nxm_reg1", r, {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 5'd2, 18'o7000});
    check("nxm_released", bus_outs(), 39'd0);
    slave_en = 1'b1;

    // INIT while waiting for SSYN
    for (int k = 0; k < 32; k++) bufm[k] = 16'($urandom);
    load_buf(32);
    arm_write(3'd3, 32'd9);
    ptr_m = 9;
    slave_en = 1'b0;
    arm_write(3'd1, {1'b1, 7'd0, 1'b1, 5'd3, 18'o4000});
    grant(1'b0, 18'o4000);
    n = 0;
    while (!msyn_out_h && n < 50) begin
      @(negedge CLOCK);
      n++;
    end
    check("init_msyn_seen", msyn_out_h, 1'b1);
    @(negedge CLOCK);
    init_in_h = 1'b1;
    @(negedge CLOCK);
    init_in_h = 1'b0;
    check("init_bus_clear", bus_outs(), 39'd0);
    arm_read(3'd1, r);
    check("init_reg1", r, {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 5'd3, 18'o4000});
    arm_read(3'd2, r);
    check("init_buf_kept", r, {11'd0, 5'(ptr_m), bufm[ptr_m]});
    slave_en = 1'b1;
    do_xfer(18'o4000, 3, 1'b1, 2, 1'b0);

    // arbitration guard plus writes while busy
    load_buf(32);
    do_xfer(18'o6000, 3, 1'b1, 1, 1'b1);
    arm_read(3'd2, r);
    check("busy_writes_ignored", r, {11'd0, 5'(ptr_m), bufm[ptr_m]});

    // randomized transfers
    for (int t = 0; t < 6; t++) begin
      ra = 18'($urandom);
      rc = $urandom_range(0, 31);
      rd = 1'($urandom_range(0, 1));
      if (rd) begin
        for (int k = 0; k <= rc; k++) bufm[k] = 16'($urandom);
        load_buf(rc + 1);
      end else begin
        for (int k = 0; k <= rc; k++) mem[int'(word_addr(ra, k))] = 16'($urandom);
      end
      do_xfer(ra, rc, rd, $urandom_range(0, 6), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
